// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module ex_muldiv #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] op_a_i,
   input  logic [DATA_WIDTH-1:0] op_b_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int unsigned W = DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e         state_q;
   logic [4:0]     cnt_q;
   logic [2:0]     funct3_q;
   logic [W-1:0]   b_mag_q;
   logic [2*W-1:0] acc_q;    // mul: {partial product, multiplier}; div: low half dividend/quotient
   logic [W-1:0]   rem_q;
   logic           neg_q;
   logic           a_neg_q;
   logic           done_q;
   logic [W-1:0]   result_q;

   // Capture-side decode: signedness, magnitudes and the special cases.
   logic         is_div, sign_a, sign_b, a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;
   logic         div_zero, div_ovf;
   logic [W-1:0] special_res;

   always_comb begin
      is_div   = funct3_i[2];
      sign_a   = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      sign_b   = is_div ? ~funct3_i[0] : ~funct3_i[1];
      a_neg    = sign_a & op_a_i[W-1];
      b_neg    = sign_b & op_b_i[W-1];
      a_mag    = a_neg ? -op_a_i : op_a_i;
      b_mag    = b_neg ? -op_b_i : op_b_i;
      div_zero = is_div && (op_b_i == '0);
      div_ovf  = is_div && !funct3_i[0] && (op_a_i == {1'b1, {(W-1){1'b0}}}) &&
                 (op_b_i == '1);
      if (div_zero) begin
         special_res = funct3_i[1] ? op_a_i : '1;
      end else begin
         special_res = funct3_i[1] ? '0 : op_a_i;
      end
   end

   logic         fast_hit;
   logic [W-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fast_a, fast_b, fast_prod;

   always_comb begin
      fast_a    = {{W{a_neg}}, op_a_i};
      fast_b    = {{W{b_neg}}, op_b_i};
      // Product of sign-extended operands, taken modulo 2^64, is the exact signed product.
      fast_prod = fast_a * fast_b;
      fast_hit  = !is_div;
      fast_res  = (funct3_i[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
   end
`else
   always_comb begin
      fast_hit = 1'b0;
      fast_res = '0;
   end
`endif

   // One iteration of shift-add multiply and restoring divide, plus the final sign fixup.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_acc_d;
   logic [W:0]     div_shift, div_diff;
   logic [W-1:0]   rem_d;
   logic [2*W-1:0] div_acc_d;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quot, rem, calc_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
      mul_acc_d = {mul_sum, acc_q[W-1:1]};
      div_shift = {rem_q, acc_q[W-1]};
      div_diff  = div_shift - {1'b0, b_mag_q};
      rem_d     = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
      div_acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W]};
      prod      = neg_q ? -mul_acc_d : mul_acc_d;
      quot      = neg_q ? -div_acc_d[W-1:0] : div_acc_d[W-1:0];
      rem       = a_neg_q ? -rem_d : rem_d;
      if (funct3_q[2]) begin
         calc_res = funct3_q[1] ? rem : quot;
      end else begin
         calc_res = (funct3_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         funct3_q <= '0;
         b_mag_q  <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else if (flush_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  funct3_q <= funct3_i;
                  b_mag_q  <= b_mag;
                  acc_q    <= {{W{1'b0}}, a_mag};
                  rem_q    <= '0;
                  neg_q    <= a_neg ^ b_neg;
                  a_neg_q  <= a_neg;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else if (fast_hit) begin
                     result_q <= fast_res;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     cnt_q   <= 5'd31;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               acc_q <= funct3_q[2] ? div_acc_d : mul_acc_d;
               rem_q <= rem_d;
               if (cnt_q == 5'd0) begin
                  result_q <= calc_res;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stall_o  = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StCalc);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule
